vga_scroll_scheduler: RTL

Frame-rate scheduler for the multi-layer scrolling checkerboard datapath. It advances the global animation counter once per scheduled frame and computes per-layer X/Y scroll offsets. A single shared add/subtract unit is time-multiplexed across layers during vertical blank. Offsets are committed atomically to shadow registers, so the pixel datapath never sees a half-updated set during active video.

---
 rtl/vga_scroll_pkg.sv | 45 ++++
 rtl/vga_frame_prescaler.sv | 55 +++++
 rtl/vga_scroll_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_scroll_pkg.sv
// Shared definitions for the scrolling checkerboard scheduler.
//   - FSM state encoding
//   - default counter / fraction widths
//   - per-layer X/Y scroll rates (eighths of a pixel per frame, layer 0 first)
//   - reverse-wrap accumulator seeds: ((2^CNT_W - 1) * rate) mod 2^(CNT_W + FRAC_W)
package vga_scroll_pkg;

    localparam int unsigned CNT_W_DEF      = 10;
    localparam int unsigned FRAC_W_DEF     = 3;
    localparam int unsigned NUM_LAYERS_DEF = 5;
    localparam int unsigned ACC_W_DEF      = CNT_W_DEF + FRAC_W_DEF;
    localparam int unsigned SPEED_W        = 2;
    // Holds up to 2^(2^SPEED_W - 1) - 1 = 7 frames of division.
    localparam int unsigned PRESC_W        = 3;

    typedef enum logic [1:0] {
        StIdle,
        StCnt,
        StLayer,
        StCommit
    } state_e;

    typedef logic [ACC_W_DEF-1:0] rate_t;

    // Layer 0 sits in the least significant slot.
    localparam rate_t [NUM_LAYERS_DEF-1:0] RATE_X = {13'd4, 13'd16, 13'd32, 13'd56, 13'd128};
    localparam rate_t [NUM_LAYERS_DEF-1:0] RATE_Y = {13'd1, 13'd2, 13'd4, 13'd12, 13'd16};

    // Accumulator value that corresponds to counter = 2^CNT_W - 1.
    function automatic rate_t rev_of(rate_t rate);
        logic [2*ACC_W_DEF-1:0] prod;
        prod = {{ACC_W_DEF{1'b0}}, rate} * (2*ACC_W_DEF)'((1 << CNT_W_DEF) - 1);
        return prod[ACC_W_DEF-1:0];
    endfunction

    localparam rate_t [NUM_LAYERS_DEF-1:0] REV_X = {
        rev_of(RATE_X[4]), rev_of(RATE_X[3]), rev_of(RATE_X[2]),
        rev_of(RATE_X[1]), rev_of(RATE_X[0])
    };
    localparam rate_t [NUM_LAYERS_DEF-1:0] REV_Y = {
        rev_of(RATE_Y[4]), rev_of(RATE_Y[3]), rev_of(RATE_Y[2]),
        rev_of(RATE_Y[1]), rev_of(RATE_Y[0])
    };

endpackage

// File: rtl/vga_frame_prescaler.sv
// Frame tick generator: vsync rising-edge detect, 2^speed frame divider,
// single-step latch for paused operation.
// Ports:
//   clk, reset  pixel clock, asynchronous active-high reset
//   vsync       vertical sync level (active high)
//   pause       1 = only latched step requests produce ticks
//   step        one-cycle step request, latched only while paused
//   speed       divider select, tick every 2^speed frames
//   idle        scheduler can accept a tick; edges seen while busy are dropped
//   tick        one-cycle pulse in the edge cycle when a frame update should run
module vga_frame_prescaler
    import vga_scroll_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               pause,
    input  logic               step,
    input  logic [SPEED_W-1:0] speed,
    input  logic               idle,
    output logic               tick
);

    logic               vsync_q;
    logic               step_pending_q;
    logic [PRESC_W-1:0] presc_q;
    logic               edge_det;
    logic               period_done;
    logic [PRESC_W:0]   period_max;

    always_comb begin
        edge_det    = vsync & ~vsync_q;
        // One extra bit so speed = 3 does not overflow the shift.
        period_max  = ((PRESC_W+1)'(1) << speed) - (PRESC_W+1)'(1);
        // >= rather than == so lowering speed still produces a prompt tick.
        period_done = {1'b0, presc_q} >= period_max;
        tick        = edge_det & idle & (pause ? step_pending_q : period_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q        <= 1'b0;
            step_pending_q <= 1'b0;
            presc_q        <= '0;
        end else begin
            vsync_q <= vsync;
            // Paused edges and edges arriving while busy leave the divider alone.
            if (edge_det && idle && !pause) begin
                presc_q <= period_done ? '0 : presc_q + PRESC_W'(1);
            end
            step_pending_q <= (step & pause) | (step_pending_q & ~tick);
        end
    end

endmodule

// File: rtl/vga_scroll_scheduler.sv
// Per-frame scroll scheduler. On each scheduled frame the animation counter
// steps by +/-1, then one shared X/Y add/subtract pair walks the layers one
// cycle each, and finally every committed output is updated in the same cycle.
// Ports:
//   clk, reset     pixel clock, asynchronous active-high reset
//   vsync          vertical sync level (active high)
//   pause, step    pause automatic ticks / request one tick while paused
//   speed          tick every 2^speed frames
//   dir            0 = count up, 1 = count down
//   counter        committed animation counter
//   layer_x_off    committed X offsets, layer 0 in the LSBs
//   layer_y_off    committed Y offsets, layer 0 in the LSBs
//   offsets_valid  one-cycle pulse while in COMMIT (outputs already updated)
//   busy           FSM is outside IDLE
module vga_scroll_scheduler
    import vga_scroll_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic                         pause,
    input  logic                         step,
    input  logic [1:0]                   speed,
    input  logic                         dir,
    output logic [CNT_W-1:0]             counter,
    output logic [NUM_LAYERS*CNT_W-1:0]  layer_x_off,
    output logic [NUM_LAYERS*CNT_W-1:0]  layer_y_off,
    output logic                         offsets_valid,
    output logic                         busy
);

    localparam int unsigned ACC_W  = CNT_W + FRAC_W;
    localparam int unsigned LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);

    state_e                  state_q;
    logic [LIDX_W-1:0]       layer_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    dir_q;
    logic                    wrap_fwd_q;
    logic                    wrap_rev_q;
    logic [ACC_W-1:0]        acc_x_q [NUM_LAYERS];
    logic [ACC_W-1:0]        acc_y_q [NUM_LAYERS];
    logic [CNT_W-1:0]        counter_q;
    logic [NUM_LAYERS*CNT_W-1:0] x_off_q;
    logic [NUM_LAYERS*CNT_W-1:0] y_off_q;
    logic                    valid_q;

    logic                    idle;
    logic                    tick;
    logic [ACC_W-1:0]        rate_x, rate_y, rev_x, rev_y;
    logic [ACC_W-1:0]        acc_x_cur, acc_y_cur;
    logic [ACC_W-1:0]        acc_x_new, acc_y_new;

    assign idle = (state_q == StIdle);

    vga_frame_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .pause (pause),
        .step  (step),
        .speed (speed),
        .idle  (idle),
        .tick  (tick)
    );

    // Shared X/Y add/subtract, operands selected by the layer being sequenced.
    always_comb begin
        rate_x    = ACC_W'(RATE_X[layer_q]);
        rate_y    = ACC_W'(RATE_Y[layer_q]);
        rev_x     = ACC_W'(REV_X[layer_q]);
        rev_y     = ACC_W'(REV_Y[layer_q]);
        acc_x_cur = acc_x_q[layer_q];
        acc_y_cur = acc_y_q[layer_q];
        // A counter wrap reseeds the accumulators so offset = counter * rate
        // holds exactly, independent of 2^CNT_W * rate modulo behaviour.
        if (wrap_fwd_q) begin
            acc_x_new = '0;
            acc_y_new = '0;
        end else if (wrap_rev_q) begin
            acc_x_new = rev_x;
            acc_y_new = rev_y;
        end else if (dir_q) begin
            acc_x_new = acc_x_cur - rate_x;
            acc_y_new = acc_y_cur - rate_y;
        end else begin
            acc_x_new = acc_x_cur + rate_x;
            acc_y_new = acc_y_cur + rate_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            layer_q    <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            wrap_fwd_q <= 1'b0;
            wrap_rev_q <= 1'b0;
            counter_q  <= '0;
            x_off_q    <= '0;
            y_off_q    <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                acc_x_q[i] <= '0;
                acc_y_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StCnt;
                    end
                end
                StCnt: begin
                    // dir is captured here and held for the rest of the sequence.
                    dir_q   <= dir;
                    layer_q <= '0;
                    state_q <= StLayer;
                    if (dir) begin
                        cnt_q      <= cnt_q - CNT_W'(1);
                        wrap_fwd_q <= 1'b0;
                        wrap_rev_q <= (cnt_q == '0);
                    end else begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        wrap_fwd_q <= &cnt_q;
                        wrap_rev_q <= 1'b0;
                    end
                end
                StLayer: begin
                    acc_x_q[layer_q] <= acc_x_new;
                    acc_y_q[layer_q] <= acc_y_new;
                    if (layer_q == LAST_LAYER) begin
                        // Load the shadow set on entry to COMMIT so the whole set
                        // and offsets_valid appear together during COMMIT.
                        state_q   <= StCommit;
                        valid_q   <= 1'b1;
                        counter_q <= cnt_q;
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (LIDX_W'(i) == layer_q) begin
                                x_off_q[i*CNT_W +: CNT_W] <= acc_x_new[ACC_W-1:FRAC_W];
                                y_off_q[i*CNT_W +: CNT_W] <= acc_y_new[ACC_W-1:FRAC_W];
                            end else begin
                                x_off_q[i*CNT_W +: CNT_W] <= acc_x_q[i][ACC_W-1:FRAC_W];
                                y_off_q[i*CNT_W +: CNT_W] <= acc_y_q[i][ACC_W-1:FRAC_W];
                            end
                        end
                    end else begin
                        layer_q <= layer_q + LIDX_W'(1);
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign counter       = counter_q;
    assign layer_x_off   = x_off_q;
    assign layer_y_off   = y_off_q;
    assign offsets_valid = valid_q;
    assign busy          = ~idle;

endmodule
